// File: rtl/sb_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sb_tx_arbiter_pkg
//   Shared definitions for the sideband TX arbiter that sits in front of the
//   single sideband serializer in LTSM_top.
//   Contents: arbiter state encoding, default message width, default
//   inter-packet gap, default requester count and a counter-width helper.
// -----------------------------------------------------------------------------
package sb_tx_arbiter_pkg;

    // Default sideband message width in bits.
    localparam int unsigned SB_MSG_W      = 64;
    // Default idle cycles enforced after the serializer's done pulse.
    localparam int unsigned SB_GAP_CYCLES = 4;
    // Default number of requesting sub-FSMs.
    localparam int unsigned SB_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } sb_tx_state_e;

    // Width of a down-counter that must hold values 0 .. n-1.
    // Never returns 0, so zero-length configurations still get a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sb_tx_arbiter_pkg

// File: rtl/sb_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Starting at ptr_i and walking upward
//   (mod NUM_REQ), selects the first set bit of req_i.
//   Ports:
//     req_i        request vector, one bit per requester
//     ptr_i        index holding highest priority this round
//     grant_o      one-hot grant (all zero when no request)
//     grant_idx_o  binary index of the granted requester (0 when none)
//     any_valid_o  at least one request bit is set
//   Kept generic so the mainband lane arbitration can reuse it.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_valid_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // NOTE: every variable written here gets a default before the loop;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_valid_o = |req_i;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/sb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// sb_tx_arbiter
//   Shares the single sideband TX serializer between the per-state sub-FSMs.
//   Requesters are granted round-robin; the granted message is latched and
//   offered to the serializer over valid/ready. After the serializer's done
//   pulse a fixed idle gap is enforced before the next grant.
//   Ports:
//     clk_100MHz   sideband-domain clock
//     reset        synchronous, active-high reset
//     enable_i     gates new grants (sampled in IDLE only)
//     req_valid_i  per-requester pending flag, held until req_ack_o
//     req_msg_i    per-requester message, slice i = [i*MSG_W +: MSG_W]
//     req_ack_o    one-cycle pulse: requester's message accepted
//     ser_valid_o  message offered to serializer
//     ser_msg_o    latched granted message
//     ser_ready_i  serializer can accept
//     ser_done_i   one-cycle pulse: serializer finished shifting
//     grant_id_o   current/last granted requester
//     busy_o       high in any state except IDLE
// -----------------------------------------------------------------------------
module sb_tx_arbiter
    import sb_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = SB_NUM_REQ,
    parameter  int unsigned MSG_W      = SB_MSG_W,
    parameter  int unsigned GAP_CYCLES = SB_GAP_CYCLES,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ),
    localparam int unsigned GAP_W      = cnt_width(GAP_CYCLES)
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*MSG_W-1:0]   req_msg_i,
    output logic [NUM_REQ-1:0]         req_ack_o,
    output logic                       ser_valid_o,
    output logic [MSG_W-1:0]           ser_msg_o,
    input  logic                       ser_ready_i,
    input  logic                       ser_done_i,
    output logic [IDX_W-1:0]           grant_id_o,
    output logic                       busy_o
);

    sb_tx_state_e         state_q,    state_d;
    logic [IDX_W-1:0]     ptr_q,      ptr_d;
    logic [IDX_W-1:0]     grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [MSG_W-1:0]     msg_q,      msg_d;
    logic [NUM_REQ-1:0]   ack_q,      ack_d;
    logic [GAP_W-1:0]     gap_cnt_q,  gap_cnt_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    // Unpacked view of the flat message bus so the granted slice is a plain
    // array lookup.
    logic [MSG_W-1:0]     req_msg_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg_split
        assign req_msg_arr[g] = req_msg_i[g*MSG_W +: MSG_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_valid_o (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        msg_d      = msg_q;
        ack_d      = '0;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // enable_i only gates the start of a transaction; once a
                // message is latched it always runs to completion.
                if (enable_i && arb_any) begin
                    state_d    = ST_SEND;
                    grant_id_d = arb_idx;
                    grant_oh_d = arb_grant;
                    msg_d      = req_msg_arr[arb_idx];
                end
            end

            ST_SEND: begin
                // ser_done_i is deliberately ignored here: no message has
                // been accepted yet, so a stray done cannot belong to us.
                if (ser_ready_i) begin
                    state_d = ST_WAIT_DONE;
                    ack_d   = grant_oh_q;
                    // Just-served requester drops to lowest priority.
                    ptr_d   = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                   : grant_id_q + IDX_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (ser_done_i) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                    end
                end
            end

            ST_GAP: begin
                // Counter loads GAP_CYCLES-1 and leaves on 0, giving exactly
                // GAP_CYCLES cycles in GAP.
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            // NOTE: the wide message register is reset too, because
            // ser_msg_o must read zero straight out of reset.
            msg_q      <= '0;
            ack_q      <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            msg_q      <= msg_d;
            ack_q      <= ack_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign req_ack_o   = ack_q;
    assign ser_valid_o = (state_q == ST_SEND);
    assign ser_msg_o   = msg_q;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule : sb_tx_arbiter
